// File: rtl/dlx_mem_pkg.sv
// Shared encodings for the DLX memory port: response owner and arbiter state.
// Imported by the arbiter, the IF stage and the MEM stage.
package dlx_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IF   = 2'b01,
      OWN_D    = 2'b10
   } owner_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/init_delay_counter.sv
// Post-reset hold-off: init_delay is high for CYCLES rising edges after reset release.
// Latency: done rises on the CYCLES-th edge; registered outputs.
// Backpressure: none, free-running once reset releases.
module init_delay_counter
   import dlx_mem_pkg::*;
#(
   parameter int CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   output logic init_delay,
   output logic done
);

   localparam int            CW   = cnt_width(CYCLES - 1);
   localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

   state_t        state;
   logic [CW-1:0] cnt;

   // Reset leaves the counter preloaded, so INIT starts counting on the first edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_INIT;
         cnt        <= LOAD;
         init_delay <= 1'b1;
         done       <= 1'b0;
      end else if (state == ST_INIT) begin
         if (cnt == '0) begin
            state      <= ST_RUN;
            init_delay <= 1'b0;
            done       <= 1'b1;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data RAM between instruction fetch and the MEM stage.
// Latency: grant is combinational from req; read data valid one cycle after grant.
// Backpressure: requests are level and held until granted; data wins, fetch bounded by STARVE_MAX.
module mem_port_arbiter
   import dlx_mem_pkg::*;
#(
   parameter int INIT_CYCLES = 4,
   parameter int STARVE_MAX  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        flush,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        ram_cs,
   output logic        ram_oe,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_din,
   input  logic [31:0] ram_dout,
   output logic        init_delay
);

   localparam int            SW         = cnt_width(STARVE_MAX);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic          run;
   logic [SW-1:0] starve_cnt;
   owner_t        rd_owner;
   logic          flush_r;

   init_delay_counter #(
      .CYCLES     (INIT_CYCLES)
   ) u_init (
      .clk        (clk),
      .reset      (reset),
      .init_delay (init_delay),
      .done       (run)
   );

   always_comb begin
      d_gnt  = run & d_req & (~if_req | (starve_cnt < STARVE_LIM));
      if_gnt = run & ~d_gnt & if_req;
   end

   assign ram_cs   = if_gnt | d_gnt;
   assign ram_we   = d_gnt & d_we;
   assign ram_oe   = ram_cs & ~ram_we;
   assign ram_addr = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
   assign ram_din  = d_gnt ? d_wdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
         rd_owner   <= OWN_NONE;
         flush_r    <= 1'b0;
      end else begin
         flush_r <= flush;
         if (!if_req || if_gnt)
            starve_cnt <= '0;
         else if (d_gnt && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + SW'(1);
         if (if_gnt)
            rd_owner <= OWN_IF;
         else if (d_gnt && !d_we)
            rd_owner <= OWN_D;
         else
            rd_owner <= OWN_NONE;
      end
   end

   // A redirect in either the grant or the response cycle kills the fetch return.
   assign if_rvalid = (rd_owner == OWN_IF) & ~(flush_r | flush);
   assign d_rvalid  = (rd_owner == OWN_D);
   assign if_rdata  = ram_dout;
   assign d_rdata   = ram_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, scored against a reference model.
module tb_mem_port_arbiter;

   localparam int INIT_CYCLES = 4;
   localparam int STARVE_MAX  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_gnt, if_rvalid, flush;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        ram_cs, ram_oe, ram_we, init_delay;
   logic [31:0] ram_addr, ram_din;
   logic [31:0] ram_dout = 32'h0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .INIT_CYCLES (INIT_CYCLES),
      .STARVE_MAX  (STARVE_MAX)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .flush      (flush),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .ram_cs     (ram_cs),
      .ram_oe     (ram_oe),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_dout   (ram_dout),
      .init_delay (init_delay)
   );

   // Power-on contents shared by the RAM stub and the reference memory.
   function automatic logic [31:0] fill(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // syncram stub: registered read, write on the clock edge.
   logic [31:0] ram_mem [logic [31:0]];
   always @(posedge clk) begin
      if (ram_cs && ram_oe)
         ram_dout <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : fill(ram_addr);
      if (ram_cs && ram_we)
         ram_mem[ram_addr] = ram_din;
   end

   // Reference model state
   logic [31:0] ref_mem [logic [31:0]];
   int fetch_wait = 0;   // data grants given while the current fetch has been pending
   int if_wait    = 0;   // observed run cycles the current fetch has waited
   int edges_run  = 0;   // rising edges since reset release
   int cyc        = 0;
   bit g_d, g_i;
   logic last_if_gnt;

   typedef struct {
      bit          is_if;
      logic [31:0] data;
      bit          flushed;
      int          due;
   } rsp_t;
   rsp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge reset) begin
      if (reset) edges_run <= 0;
      else       edges_run <= edges_run + 1;
   end

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fill(a);
   endfunction

   // Grant rules applied to the current inputs, checked against the DUT, then the model advances.
   task automatic check_cycle();
      bit          in_run, e_d, e_i, e_we;
      logic [31:0] e_addr;
      in_run = !reset && (edges_run >= INIT_CYCLES);
      e_d    = in_run && d_req && (!if_req || fetch_wait < STARVE_MAX);
      e_i    = in_run && !e_d && if_req;
      e_we   = e_d && d_we;
      e_addr = e_d ? d_addr : (e_i ? if_addr : 32'h0);

      check1("init_delay", init_delay, !in_run);
      check1("if_gnt", if_gnt, e_i);
      check1("d_gnt", d_gnt, e_d);
      check1("ram_cs", ram_cs, e_d || e_i);
      check1("ram_we", ram_we, e_we);
      check1("ram_oe", ram_oe, (e_d || e_i) && !e_we);
      check32("ram_addr", ram_addr, e_addr);
      if (!e_i) check32("ram_din", ram_din, e_d ? d_wdata : 32'h0);

      if (if_gnt) begin
         check1("fetch_wait_bound", if_wait <= STARVE_MAX, 1'b1);
         if_wait = 0;
      end else if (!if_req || reset) begin
         if_wait = 0;
      end else if (in_run) begin
         if_wait++;
      end
      last_if_gnt = if_gnt;

      if (e_d && !d_we) exp_q.push_back('{1'b0, ref_rd(d_addr), 1'b0, cyc + 1});
      if (e_i)          exp_q.push_back('{1'b1, ref_rd(if_addr), flush, cyc + 1});
      if (e_we)         ref_mem[d_addr] = d_wdata;
      if (!if_req || e_i) fetch_wait = 0;
      else if (e_d)       fetch_wait++;
      g_d = e_d;
      g_i = e_i;
   endtask

   // Response monitor: pops whatever read return is due this cycle.
   rsp_t        m_r;
   bit          m_if, m_d;
   logic [31:0] m_dat;
   always @(negedge clk) begin
      m_if  = 1'b0;
      m_d   = 1'b0;
      m_dat = 32'h0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         m_r   = exp_q.pop_front();
         m_if  = m_r.is_if && !(m_r.flushed || flush);
         m_d   = !m_r.is_if;
         m_dat = m_r.data;
      end
      check1("if_rvalid", if_rvalid, m_if);
      check1("d_rvalid", d_rvalid, m_d);
      if (m_if) check32("if_rdata", if_rdata, m_dat);
      if (m_d)  check32("d_rdata", d_rdata, m_dat);
      check1("rvalid_exclusive", if_rvalid && d_rvalid, 1'b0);
   end

   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
      if (g_d) d_req = 1'b0;
      if (g_i) if_req = 1'b0;
      flush = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      exp_q.delete();
      fetch_wait = 0;
      if_wait    = 0;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && (d_req || if_req); k++) tick();
      check1("drain", d_req || if_req, 1'b0);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; flush = 1'b0;
      if_req = 1'b0; if_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      ram_mem[32'h20] = 32'hDEADBEEF;
      ref_mem[32'h20] = 32'hDEADBEEF;
      @(posedge clk); #1;

      // Reset and INIT with a load waiting
      d_req = 1'b1; d_addr = 32'h10;
      do_reset(3);
      drain();

      // Starvation bound: D, D, D, IF repeating
      for (int k = 0; k < 8; k++) begin
         d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100 + 32'(k * 4);
         if_req = 1'b1; if_addr = 32'h200 + 32'(k * 4);
         tick();
         check1("starve_pattern", last_if_gnt, (k % 4) == 3);
      end
      drain();

      // Load then fetch back to back
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      tick();
      if_req = 1'b1; if_addr = 32'h24;
      tick();
      drain();

      // Store then load back
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
      tick();
      d_req = 1'b1; d_we = 1'b0;
      tick();
      drain();

      // Flush in response cycle, then in grant cycle, then a clean fetch
      if_req = 1'b1; if_addr = 32'h80;
      tick();
      flush = 1'b1;
      if_req = 1'b1; if_addr = 32'h84; flush = 1'b1;
      tick();
      if_req = 1'b1; if_addr = 32'h88;
      tick();
      drain();

      // Reset while a fetch response is in flight
      if_req = 1'b1; if_addr = 32'h8C;
      tick();
      do_reset(2);
      repeat (INIT_CYCLES + 1) tick();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if (!d_req && ($urandom_range(0, 2) == 0)) begin
            d_req   = 1'b1;
            d_we    = ($urandom_range(0, 2) == 0);
            d_addr  = 32'($urandom_range(0, 15)) << 2;
            d_wdata = $urandom;
         end
         if (!if_req && ($urandom_range(0, 1) == 0)) begin
            if_req  = 1'b1;
            if_addr = 32'($urandom_range(0, 15)) << 2;
         end
         flush = ($urandom_range(0, 7) == 0);
         if (i == 1500) do_reset(2);
         tick();
      end
      drain();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
